mem_io_responder: RTL and testbench



---
 rtl/mem_io_responder_pkg.sv | 40 ++++
 rtl/byte_fifo.sv | 45 ++++
 rtl/mem_io_responder.sv | 152 +++++++++++++++
 tb/tb_mem_io_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU-side memory/IO responder.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_UART   = 18'h30000;
    localparam logic [17:0] IO_CLK    = 18'h30004;
    localparam logic [1:0]  IO_REGION = 2'b11;

    typedef struct packed {
        logic       is_stop;
        logic [7:0] data;
    } txq_entry_t;

    typedef enum logic [2:0] {
        SelRam,
        SelUart,
        SelClk0,
        SelClk1,
        SelClk2,
        SelClk3,
        SelNone
    } io_sel_e;

    function automatic io_sel_e decode_addr(input logic [17:0] a);
        io_sel_e sel;
        if (a[17:16] != IO_REGION) begin
            sel = SelRam;
        end else begin
            case (a)
                IO_UART:         sel = SelUart;
                IO_CLK:          sel = SelClk0;
                IO_CLK + 18'd1:  sel = SelClk1;
                IO_CLK + 18'd2:  sel = SelClk2;
                IO_CLK + 18'd3:  sel = SelClk3;
                default:         sel = SelNone;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with occupancy count; pop frees a slot for a same-cycle push when full.
module byte_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(Depth):0]   count
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory/IO responder: byte RAM, UART TX/RX ports, cycle counter and stop latch
// behind the CPU's one-access-per-cycle byte bus.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_AW      = 17,
    parameter int unsigned TXQ_DEPTH   = 16,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halted,
    output logic        txq_overflow
);
    localparam int unsigned   CW         = $clog2(TXQ_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(TXQ_DEPTH - FULL_MARGIN);

    logic [7:0] ram [2**RAM_AW];
    logic [7:0] ram_rd_q;
    logic       rd_ram_q;
    logic [7:0] io_rd_q, io_rd_d;

    logic       hold_valid_q;
    logic [7:0] hold_data_q;
    logic [31:0] cnt_q, snap_q;
    logic       stop_pending_q, stop_wait_q, halted_q, overflow_q, buf_full_q;

    io_sel_e    sel;
    logic       is_read, ram_we, uart_rd, uart_wr, clk_rd, stop_wr;
    logic       data_req, stop_req, room, push_data, push_stop;
    logic       fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count, count_next;
    txq_entry_t fifo_wdata, txq_head;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^cpu_a[31:18];

    assign sel     = decode_addr(cpu_a[17:0]);
    assign is_read = !cpu_wr;
    assign ram_we  = cpu_wr && (sel == SelRam);
    assign uart_rd = is_read && (sel == SelUart);
    assign uart_wr = cpu_wr && (sel == SelUart);
    assign clk_rd  = is_read && (sel == SelClk0);
    assign stop_wr = cpu_wr && (sel == SelClk0);

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[cpu_a[RAM_AW-1:0]] <= cpu_dout;
        end
        ram_rd_q <= ram[cpu_a[RAM_AW-1:0]];
    end

    always_comb begin
        io_rd_d = 8'h00;
        case (sel)
            SelUart: io_rd_d = hold_valid_q ? hold_data_q : 8'h00;
            SelClk0: io_rd_d = cnt_q[7:0];
            SelClk1: io_rd_d = snap_q[15:8];
            SelClk2: io_rd_d = snap_q[23:16];
            SelClk3: io_rd_d = snap_q[31:24];
            default: io_rd_d = 8'h00;
        endcase
    end

    // Once a stop is pending, data bytes are refused, so a marker that finds the
    // FIFO full waits in stop_wait_q and is guaranteed the next slot that frees.
    assign fifo_pop  = tx_valid && tx_ready;
    assign room      = !fifo_full || fifo_pop;
    assign data_req  = uart_wr && !stop_pending_q && (cpu_dout != 8'h00);
    assign stop_req  = (stop_wr && !stop_pending_q) || stop_wait_q;
    assign push_stop = stop_req && room;
    assign push_data = data_req && room;
    assign fifo_push = push_stop || push_data;

    always_comb begin
        fifo_wdata.is_stop = push_stop;
        fifo_wdata.data    = push_stop ? 8'h00 : cpu_dout;
    end

    assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    byte_fifo #(
        .Width ($bits(txq_entry_t)),
        .Depth (TXQ_DEPTH)
    ) u_txq (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push     (fifo_push),
        .wdata    (fifo_wdata),
        .pop      (fifo_pop),
        .rdata    (txq_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ram_q       <= 1'b0;
            io_rd_q        <= 8'h00;
            hold_valid_q   <= 1'b0;
            hold_data_q    <= 8'h00;
            cnt_q          <= 32'd0;
            snap_q         <= 32'd0;
            stop_pending_q <= 1'b0;
            stop_wait_q    <= 1'b0;
            halted_q       <= 1'b0;
            overflow_q     <= 1'b0;
            buf_full_q     <= 1'b0;
        end else begin
            rd_ram_q <= is_read && (sel == SelRam);
            io_rd_q  <= is_read ? io_rd_d : 8'h00;

            if (rx_valid && rx_ready) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= rx_data;
            end else if (uart_rd) begin
                hold_valid_q <= 1'b0;
            end

            if (!halted_q) cnt_q  <= cnt_q + 32'd1;
            if (clk_rd)    snap_q <= cnt_q;

            if (stop_wr)                      stop_pending_q <= 1'b1;
            stop_wait_q <= stop_req && !room;
            if (data_req && !room)            overflow_q     <= 1'b1;
            if (fifo_pop && txq_head.is_stop) halted_q       <= 1'b1;

            buf_full_q <= (count_next >= FULL_LEVEL);
        end
    end

    assign cpu_din        = rd_ram_q ? ram_rd_q : io_rd_q;
    assign io_buffer_full = buf_full_q;
    assign tx_valid       = !fifo_empty;
    assign tx_data        = txq_head.data;
    assign rx_ready       = !hold_valid_q;
    assign halted         = halted_q;
    assign txq_overflow   = overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: queue/array reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_mem_io_responder;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halted;
    logic        txq_overflow;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .cpu_a          (cpu_a),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .halted         (halted),
        .txq_overflow   (txq_overflow)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0]  m_ram [int];
    logic [8:0]  m_q [$];
    logic        m_hold_v;
    logic [7:0]  m_hold_d;
    logic [31:0] m_cnt, m_snap;
    logic        m_stop_pend, m_stop_wait, m_halted, m_ovf, m_full;
    logic [7:0]  m_din;
    logic        m_din_known;
    logic [7:0]  seen [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold_v    = 1'b0;
        m_hold_d    = 8'h00;
        m_cnt       = 32'd0;
        m_snap      = 32'd0;
        m_stop_pend = 1'b0;
        m_stop_wait = 1'b0;
        m_halted    = 1'b0;
        m_ovf       = 1'b0;
        m_full      = 1'b0;
        m_din       = 8'h00;
        m_din_known = 1'b1;
    endtask

    task automatic model_step();
        logic [17:0] a;
        logic [8:0]  e;
        logic        io, popped_stop, cap, rd_uart, known_n;
        logic [7:0]  din_n;
        int          idx;
        a           = cpu_a[17:0];
        io          = (a[17:16] == 2'b11);
        popped_stop = 1'b0;
        din_n       = 8'h00;
        known_n     = 1'b0;
        if (m_q.size() != 0 && tx_ready) begin
            e = m_q.pop_front();
            popped_stop = e[8];
        end
        rd_uart = io && !cpu_wr && (a == 18'h30000);
        cap     = rx_valid && !m_hold_v;
        if (!io) begin
            idx = int'(a[16:0]);
            if (cpu_wr) m_ram[idx] = cpu_dout;
            else if (m_ram.exists(idx)) begin
                din_n   = m_ram[idx];
                known_n = 1'b1;
            end
        end else if (!cpu_wr) begin
            known_n = 1'b1;
            case (a)
                18'h30000: din_n = m_hold_v ? m_hold_d : 8'h00;
                18'h30004: begin din_n = m_cnt[7:0]; m_snap = m_cnt; end
                18'h30005: din_n = m_snap[15:8];
                18'h30006: din_n = m_snap[23:16];
                18'h30007: din_n = m_snap[31:24];
                default:   din_n = 8'h00;
            endcase
        end else begin
            if (a == 18'h30000 && !m_stop_pend && cpu_dout != 8'h00) begin
                if (m_q.size() < DEPTH) m_q.push_back({1'b0, cpu_dout});
                else m_ovf = 1'b1;
            end
            if (a == 18'h30004 && !m_stop_pend) begin
                m_stop_pend = 1'b1;
                m_stop_wait = 1'b1;
            end
        end
        if (m_stop_wait && m_q.size() < DEPTH) begin
            m_q.push_back({1'b1, 8'h00});
            m_stop_wait = 1'b0;
        end
        if (cap) begin
            m_hold_v = 1'b1;
            m_hold_d = rx_data;
        end else if (rd_uart) begin
            m_hold_v = 1'b0;
        end
        if (!m_halted) m_cnt = m_cnt + 32'd1;
        if (popped_stop) m_halted = 1'b1;
        m_full      = (DEPTH - m_q.size()) <= MARGIN;
        m_din       = din_n;
        m_din_known = known_n;
    endtask

    task automatic compare();
        if (m_din_known) chk("cpu_din", cpu_din, m_din);
        chk("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0][7:0]);
        chk("rx_ready", rx_ready, !m_hold_v);
        chk("halted", halted, m_halted);
        chk("txq_overflow", txq_overflow, m_ovf);
        chk("io_buffer_full", io_buffer_full, m_full);
    endtask

    // One clock: record a TX handshake, advance model on the edge, check 1 ns later.
    task automatic tick();
        if (rst_n && tx_valid && tx_ready) seen.push_back(tx_data);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare();
    endtask

    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
        tick();
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_din"}, cpu_din, 8'h00);
        chk({tag, "_io_buffer_full"}, io_buffer_full, 1'b0);
        chk({tag, "_tx_valid"}, tx_valid, 1'b0);
        chk({tag, "_rx_ready"}, rx_ready, 1'b1);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_txq_overflow"}, txq_overflow, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("por");
        tick(); tick(); tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        bus(32'h0, 1'b1, 8'h5A);

        // Counter snapshot at 0x12F0
        for (int i = 0; i < 10000 && m_cnt != 32'h12F0; i++) tick();
        if (m_cnt != 32'h12F0) begin
            n_run++; n_fail++;
            $display("FAIL cnt_reach: got %0h, expected 12f0", m_cnt);
        end
        bus(32'h30004, 1'b0, 8'h00); chk("clk_b0", cpu_din, 8'hF0);
        bus(32'h30005, 1'b0, 8'h00); chk("clk_b1", cpu_din, 8'h12);
        bus(32'h30006, 1'b0, 8'h00); chk("clk_b2", cpu_din, 8'h00);
        bus(32'h30007, 1'b0, 8'h00); chk("clk_b3", cpu_din, 8'h00);

        // RAM, including the top address, an alias and a non-decoded IO address
        bus(32'h00100, 1'b1, 8'hA5);
        bus(32'h00100, 1'b0, 8'h00); chk("ram_100", cpu_din, 8'hA5);
        bus(32'h1FFFF, 1'b1, 8'h3C);
        bus(32'h1FFFF, 1'b0, 8'h00); chk("ram_1ffff", cpu_din, 8'h3C);
        bus(32'h20100, 1'b0, 8'h00); chk("ram_alias", cpu_din, 8'hA5);
        bus(32'h30010, 1'b1, 8'hEE);
        bus(32'h30010, 1'b0, 8'h00); chk("io_other", cpu_din, 8'h00);
        bus(32'h00100, 1'b0, 8'h00); chk("ram_kept", cpu_din, 8'hA5);

        // "Hi" plus a filtered 0x00
        bus(32'h30000, 1'b1, 8'h48);
        bus(32'h30000, 1'b1, 8'h69);
        bus(32'h30000, 1'b1, 8'h00);
        chk("hi_head", tx_data, 8'h48);
        seen.delete();
        tx_ready = 1'b1;
        repeat (4) tick();
        tx_ready = 1'b0;
        chk("hi_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("hi_0", seen[0], 8'h48);
            chk("hi_1", seen[1], 8'h69);
        end

        // RX holding register
        rx_data = 8'h41; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("rx_ready_lo", rx_ready, 1'b0);
        bus(32'h30000, 1'b0, 8'h00);
        chk("rx_read", cpu_din, 8'h41);
        chk("rx_ready_hi", rx_ready, 1'b1);
        bus(32'h30000, 1'b0, 8'h00); chk("rx_empty", cpu_din, 8'h00);
        rx_data = 8'h55; rx_valid = 1'b1;
        bus(32'h30000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        chk("rx_race_empty", cpu_din, 8'h00);
        chk("rx_race_capt", rx_ready, 1'b0);
        rx_data = 8'h66; rx_valid = 1'b1;
        bus(32'h30000, 1'b0, 8'h00);
        chk("rx_race_old", cpu_din, 8'h55);
        tick();
        rx_valid = 1'b0;
        bus(32'h30000, 1'b0, 8'h00); chk("rx_race_new", cpu_din, 8'h66);

        // Fill, near-full flag, overflow, push+pop while full
        for (int i = 1; i <= 17; i++) begin
            bus(32'h30000, 1'b1, 8'(i));
            if (i == 13) chk("nf_13", io_buffer_full, 1'b0);
            if (i == 14) chk("nf_14", io_buffer_full, 1'b1);
            if (i == 16) chk("ovf_16", txq_overflow, 1'b0);
        end
        chk("ovf_17", txq_overflow, 1'b1);
        seen.delete();
        tx_ready = 1'b1;
        bus(32'h30000, 1'b1, 8'h77);
        chk("full_pushpop_nf", io_buffer_full, 1'b1);
        for (int i = 0; i < 40 && tx_valid; i++) tick();
        chk("drain_count", seen.size(), 17);
        if (seen.size() == 17) begin
            chk("drain_first", seen[0], 8'h01);
            chk("drain_16", seen[15], 8'h10);
            chk("drain_last", seen[16], 8'h77);
        end
        tx_ready = 1'b0;

        // Stop marker and halt
        do_reset();
        bus(32'h30000, 1'b1, 8'h31);
        bus(32'h30000, 1'b1, 8'h32);
        bus(32'h30000, 1'b1, 8'h33);
        bus(32'h30004, 1'b1, 8'h00);
        bus(32'h30000, 1'b1, 8'h99);
        chk("stop_drop_noovf", txq_overflow, 1'b0);
        seen.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && seen.size() < 4; i++) tick();
        chk("halt_after_marker", halted, 1'b1);
        chk("stop_count", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("stop_b0", seen[0], 8'h31);
            chk("stop_b2", seen[2], 8'h33);
            chk("stop_mark", seen[3], 8'h00);
        end
        bus(32'h30004, 1'b0, 8'h00);
        repeat (5) tick();
        bus(32'h30004, 1'b0, 8'h00);

        // Reset in the middle of a stream with a pending stop and held RX byte
        do_reset();
        tx_ready = 1'b0;
        bus(32'h30000, 1'b1, 8'h61);
        bus(32'h30000, 1'b1, 8'h62);
        bus(32'h30000, 1'b1, 8'h63);
        bus(32'h30004, 1'b1, 8'h00);
        tx_ready = 1'b1;
        rx_data = 8'h12; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("mid_rx_held", rx_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid");
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("post_tx_valid", tx_valid, 1'b0);
        chk("post_halted", halted, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
